// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter for the split I/D cache rv32i system.
// Grants one whole line transaction at a time to the I-cache or D-cache.
module pmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int ARB_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DONE
    } state_t;

    state_t state;
    // 1 when the most recent grant went to D
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   tie_to_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // On a tie, fixed mode always favours D; round-robin favours whoever lost last
    assign tie_to_d = (ARB_MODE == 0) ? 1'b1 : ~last_d;

    // Grant sequencing: one line transaction, then a dead cycle before re-arbitrating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req && d_req) begin
                        state  <= tie_to_d ? GRANT_D : GRANT_I;
                        last_d <= tie_to_d;
                    end else if (d_req) begin
                        state  <= GRANT_D;
                        last_d <= 1'b1;
                    end else if (i_req) begin
                        state  <= GRANT_I;
                        last_d <= 1'b0;
                    end
                end
                GRANT_I: begin
                    if (pmem_resp) state <= DONE;
                end
                GRANT_D: begin
                    if (pmem_resp) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Route the granted requester to memory and the memory response back to it
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state)
            GRANT_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            GRANT_D: begin
                // A simultaneous read and write is resolved as a write-back
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    // Read data is shared; only the side seeing resp treats it as valid
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: a round-robin instance (a)
// and a fixed-priority instance (b), each with its own memory model.
module tb_pmem_arbiter;

    localparam int LAT    = 5;
    localparam int BUDGET = 200;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] a;
        logic [255:0] wd;
    } exp_t;

    logic clk;
    logic rst_n;

    logic         i_read_a, d_read_a, d_write_a;
    logic [31:0]  i_addr_a, d_addr_a;
    logic [255:0] d_wdata_a;
    logic         i_resp_a, d_resp_a;
    logic [255:0] i_rdata_a, d_rdata_a;
    logic         pm_read_a, pm_write_a, pm_resp_a;
    logic [31:0]  pm_addr_a;
    logic [255:0] pm_wdata_a, pm_rdata_a;
    int           cnt_a;

    logic         i_read_b, d_read_b, d_write_b;
    logic [31:0]  i_addr_b, d_addr_b;
    logic [255:0] d_wdata_b;
    logic         i_resp_b, d_resp_b;
    logic [255:0] i_rdata_b, d_rdata_b;
    logic         pm_read_b, pm_write_b, pm_resp_b;
    logic [31:0]  pm_addr_b;
    logic [255:0] pm_wdata_b, pm_rdata_b;
    int           cnt_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    pmem_arbiter #(.ADDR_W(32), .LINE_W(256), .ARB_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read_a), .i_address(i_addr_a),
        .i_resp(i_resp_a), .i_rdata(i_rdata_a),
        .d_read(d_read_a), .d_write(d_write_a),
        .d_address(d_addr_a), .d_wdata(d_wdata_a),
        .d_resp(d_resp_a), .d_rdata(d_rdata_a),
        .pmem_read(pm_read_a), .pmem_write(pm_write_a),
        .pmem_address(pm_addr_a), .pmem_wdata(pm_wdata_a),
        .pmem_resp(pm_resp_a), .pmem_rdata(pm_rdata_a)
    );

    pmem_arbiter #(.ADDR_W(32), .LINE_W(256), .ARB_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read_b), .i_address(i_addr_b),
        .i_resp(i_resp_b), .i_rdata(i_rdata_b),
        .d_read(d_read_b), .d_write(d_write_b),
        .d_address(d_addr_b), .d_wdata(d_wdata_b),
        .d_resp(d_resp_b), .d_rdata(d_rdata_b),
        .pmem_read(pm_read_b), .pmem_write(pm_write_b),
        .pmem_address(pm_addr_b), .pmem_wdata(pm_wdata_b),
        .pmem_resp(pm_resp_b), .pmem_rdata(pm_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{32'hA5A5_A5A5 ^ a}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model a: responds LAT cycles after a strobe appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0;
            pm_resp_a <= 1'b0;
            pm_rdata_a <= '0;
        end else if (pm_resp_a) begin
            pm_resp_a <= 1'b0;
            cnt_a <= 0;
        end else if (pm_read_a || pm_write_a) begin
            if (cnt_a == LAT - 1) begin
                pm_resp_a <= 1'b1;
                pm_rdata_a <= line_of(pm_addr_a);
            end else begin
                cnt_a <= cnt_a + 1;
            end
        end else begin
            cnt_a <= 0;
        end
    end

    // Memory model b: same behaviour for the fixed-priority instance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b <= 0;
            pm_resp_b <= 1'b0;
            pm_rdata_b <= '0;
        end else if (pm_resp_b) begin
            pm_resp_b <= 1'b0;
            cnt_b <= 0;
        end else if (pm_read_b || pm_write_b) begin
            if (cnt_b == LAT - 1) begin
                pm_resp_b <= 1'b1;
                pm_rdata_b <= line_of(pm_addr_b);
            end else begin
                cnt_b <= cnt_b + 1;
            end
        end else begin
            cnt_b <= 0;
        end
    end

    task automatic mon(input int k, input logic ir, input logic dr,
                       input logic pr, input logic pw, input logic presp,
                       input logic [31:0] pa, input logic [255:0] pwd,
                       input logic [255:0] ird, input logic [255:0] drd);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q_a.size() : q_b.size();
        if (presp && !(ir || dr))
            chk("resp_fwd", 1'b0, 1'b1);
        if (ir || dr) begin
            if (sz == 0) begin
                chk("spurious_resp", 1'b1, 1'b0);
            end else begin
                if (k == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                chk("i_resp", ir, !e.is_d);
                chk("d_resp", dr, e.is_d);
                chk("addr", pa, e.a);
                chk("pwrite", pw, e.wr);
                chk("pread", pr, !e.wr);
                chk("wdata", pwd, e.is_d ? e.wd : 256'd0);
                if (!e.wr)
                    chk("rdata", e.is_d ? drd : ird, line_of(e.a));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, i_resp_a, d_resp_a, pm_read_a, pm_write_a, pm_resp_a,
            pm_addr_a, pm_wdata_a, i_rdata_a, d_rdata_a);
        mon(1, i_resp_b, d_resp_b, pm_read_b, pm_write_b, pm_resp_b,
            pm_addr_b, pm_wdata_b, i_rdata_b, d_rdata_b);
    end

    task automatic push(input int k, input bit is_d, input bit wr,
                        input logic [31:0] a, input logic [255:0] wd);
        exp_t e;
        e.is_d = is_d;
        e.wr = wr;
        e.a = a;
        e.wd = wd;
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic i_req(input int k, input logic [31:0] a);
        int  n;
        logic r;
        n = 0;
        if (k == 0) begin i_read_a = 1'b1; i_addr_a = a; end
        else        begin i_read_b = 1'b1; i_addr_b = a; end
        do begin
            @(negedge clk);
            n++;
            r = (k == 0) ? i_resp_a : i_resp_b;
        end while (!r && n < BUDGET);
        if (!r) chk("i_timeout", 1'b0, 1'b1);
        #1;
        if (k == 0) i_read_a = 1'b0;
        else        i_read_b = 1'b0;
    endtask

    task automatic d_req(input int k, input logic [31:0] a, input bit wr,
                         input logic [255:0] wd);
        int  n;
        logic r;
        n = 0;
        if (k == 0) begin
            d_read_a = !wr; d_write_a = wr; d_addr_a = a; d_wdata_a = wd;
        end else begin
            d_read_b = !wr; d_write_b = wr; d_addr_b = a; d_wdata_b = wd;
        end
        do begin
            @(negedge clk);
            n++;
            r = (k == 0) ? d_resp_a : d_resp_b;
        end while (!r && n < BUDGET);
        if (!r) chk("d_timeout", 1'b0, 1'b1);
        #1;
        if (k == 0) begin d_read_a = 1'b0; d_write_a = 1'b0; end
        else        begin d_read_b = 1'b0; d_write_b = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] pat;
        int n;
        pat = {8{32'hDEAD_BEEF}} ^ {4{64'h0123_4567_89AB_CDEF}};
        rst_n = 1'b0;
        i_read_a = 0; d_read_a = 0; d_write_a = 0;
        i_addr_a = 0; d_addr_a = 0; d_wdata_a = 0;
        i_read_b = 0; d_read_b = 0; d_write_b = 0;
        i_addr_b = 0; d_addr_b = 0; d_wdata_b = 0;
        repeat (2) @(negedge clk);
        chk("rst_pread", pm_read_a, 1'b0);
        chk("rst_pwrite", pm_write_a, 1'b0);
        chk("rst_addr", pm_addr_a, 32'd0);
        chk("rst_wdata", pm_wdata_a, 256'd0);
        chk("rst_resp", {i_resp_a, d_resp_a, i_resp_b, d_resp_b}, 4'd0);
        rst_n = 1'b1;

        // I read alone, strobe one cycle after request
        @(negedge clk);
        push(0, 0, 0, 32'h0000_0060, 256'd0);
        fork
            i_req(0, 32'h0000_0060);
            begin
                @(negedge clk);
                chk("t1_pread", pm_read_a, 1'b1);
                chk("t1_addr", pm_addr_a, 32'h0000_0060);
            end
        join

        // D write-back alone, then a dead cycle
        @(negedge clk);
        push(0, 1, 1, 32'h0000_1000, pat);
        d_req(0, 32'h0000_1000, 1, pat);
        @(negedge clk);
        chk("t2_done_strb", {pm_read_a, pm_write_a}, 2'b00);
        chk("t2_done_resp", {i_resp_a, d_resp_a}, 2'b00);

        // Round-robin with both held: I, D, I, D
        @(negedge clk);
        push(0, 0, 0, 32'h0000_0100, 256'd0);
        push(0, 1, 0, 32'h0000_2000, 256'h11);
        push(0, 0, 0, 32'h0000_0140, 256'd0);
        push(0, 1, 0, 32'h0000_2040, 256'h22);
        fork
            begin
                i_req(0, 32'h0000_0100);
                i_req(0, 32'h0000_0140);
            end
            begin
                d_req(0, 32'h0000_2000, 0, 256'h11);
                d_req(0, 32'h0000_2040, 0, 256'h22);
            end
        join

        // D arrives during GRANT_I: waits, address held, gap to D strobe
        @(negedge clk);
        push(0, 0, 0, 32'h0000_0200, 256'd0);
        push(0, 1, 1, 32'h0000_3000, ~pat);
        fork
            i_req(0, 32'h0000_0200);
            begin
                repeat (2) @(negedge clk);
                d_req(0, 32'h0000_3000, 1, ~pat);
            end
            begin
                repeat (3) @(negedge clk);
                chk("t5_hold_addr", pm_addr_a, 32'h0000_0200);
                n = 0;
                while (!i_resp_a && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!pm_write_a && n < BUDGET);
                chk("t5_d_gap", n, 3);
            end
        join

        // Fixed priority with both held: D, D, then I, I
        @(negedge clk);
        push(1, 1, 0, 32'h0000_4000, 256'h33);
        push(1, 1, 0, 32'h0000_4040, 256'h44);
        push(1, 0, 0, 32'h0000_0300, 256'd0);
        push(1, 0, 0, 32'h0000_0340, 256'd0);
        fork
            begin
                i_req(1, 32'h0000_0300);
                i_req(1, 32'h0000_0340);
            end
            begin
                d_req(1, 32'h0000_4000, 0, 256'h33);
                d_req(1, 32'h0000_4040, 0, 256'h44);
            end
        join

        // Async reset in the middle of a D write-back
        @(negedge clk);
        d_write_a = 1'b1;
        d_addr_a = 32'h0000_5000;
        d_wdata_a = pat;
        @(negedge clk);
        chk("t6_pwrite_pre", pm_write_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pwrite_rst", pm_write_a, 1'b0);
        chk("t6_dresp_rst", d_resp_a, 1'b0);
        chk("t6_addr_rst", pm_addr_a, 32'd0);
        chk("t6_wdata_rst", pm_wdata_a, 256'd0);
        d_write_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(0, 0, 0, 32'h0000_0400, 256'd0);
        i_req(0, 32'h0000_0400);
        repeat (4) @(negedge clk);

        chk("sb_empty_a", q_a.size(), 0);
        chk("sb_empty_b", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
